puf_race_sequencer: RTL and testbench

- Sequences a race-arbiter PUF cell to produce one multi-bit response word.
- For each response bit, it drives a challenge, arms the arbiter enable and fires the race launch pulse. It then waits a settle time, drops the enable (the arbiter captures on that falling edge) and samples the arbiter output.
- Sits between the host/UART command logic and the delay-chain + arbiter datapath.
- The collected word is returned through a valid/ready handshake.

---
 rtl/puf_pkg.sv | 25 ++
 rtl/puf_settle_timer.sv | 30 +++
 rtl/puf_race_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_puf_race_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and constants for the race-arbiter PUF sequencers.
// The optional majority-vote mode is enabled by defining PUF_VOTE_EN.
package puf_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      LAUNCH,
      SETTLE,
      CAPTURE,
      SAMPLE,
      DONE
   } puf_state_t;

   localparam int CHAL_W_DEF        = 8;
   localparam int RESP_BITS_DEF     = 16;
   localparam int SETTLE_CYCLES_DEF = 8;
   localparam int VOTE_N            = 3;

   // Counter width for a range of n values, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/puf_settle_timer.sv
// Loadable up/down counter with a terminal-count flag.
// Used to time the race settle window of the PUF sequencers.
module puf_settle_timer #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_en,
   input  logic             i_down,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic [CNT_W-1:0] i_term,
   output logic             o_done
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en) begin
         r_count <= i_down ? (r_count - CNT_W'(1)) : (r_count + CNT_W'(1));
      end
   end

   assign o_done = (r_count == i_term);

endmodule

// File: rtl/puf_race_sequencer.sv
// Drives a race-arbiter PUF cell bit by bit and returns the response word
// over a valid/ready handshake. Define PUF_VOTE_EN for 3-race majority voting.
module puf_race_sequencer
   import puf_pkg::*;
#(
   parameter int CHAL_W        = CHAL_W_DEF,
   parameter int RESP_BITS     = RESP_BITS_DEF,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CHAL_W-1:0]    challenge_seed,
   output logic                 busy,
   output logic [CHAL_W-1:0]    challenge,
   output logic                 race_launch,
   output logic                 arb_enable,
   input  logic                 arb_out,
   output logic [RESP_BITS-1:0] resp_data,
   output logic                 resp_valid,
   input  logic                 resp_ready
);

   localparam int BW = cnt_width(RESP_BITS);
   localparam int SW = cnt_width(SETTLE_CYCLES);
   localparam logic [BW-1:0] LAST_BIT    = BW'(RESP_BITS - 1);
   localparam logic [SW-1:0] SETTLE_TERM = SW'(SETTLE_CYCLES - 1);

   puf_state_t           r_state, w_state_nxt;
   logic [CHAL_W-1:0]    r_chal, w_chal_nxt;
   logic [BW-1:0]        r_bit, w_bit_nxt;
   logic [RESP_BITS-1:0] r_data, w_data_nxt;
   logic                 r_busy, w_busy_nxt;
   logic                 r_launch, w_launch_nxt;
   logic                 r_enable, w_enable_nxt;
   logic                 r_valid, w_valid_nxt;

   logic w_tmr_load, w_tmr_en, w_tmr_done;
   logic w_race_more, w_bit_val;

   assign w_tmr_load = (r_state == LAUNCH);
   assign w_tmr_en   = (r_state == SETTLE);

   puf_settle_timer #(
      .CNT_W (SW)
   ) u_settle_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_tmr_load),
      .i_en       (w_tmr_en),
      .i_down     (1'b0),
      .i_load_val ('0),
      .i_term     (SETTLE_TERM),
      .o_done     (w_tmr_done)
   );

`ifdef PUF_VOTE_EN
   logic [1:0] r_vote_idx, w_vote_idx_nxt;
   logic [1:0] r_ones, w_ones_nxt, w_ones_sum;

   // The current sample is folded into the ones count before the vote is taken.
   assign w_ones_sum  = r_ones + {1'b0, arb_out};
   assign w_race_more = (r_vote_idx != 2'(VOTE_N - 1));
   assign w_bit_val   = (w_ones_sum >= 2'd2);

   always_comb begin
      w_vote_idx_nxt = r_vote_idx;
      w_ones_nxt     = r_ones;
      if (r_state == SAMPLE) begin
         if (w_race_more) begin
            w_vote_idx_nxt = r_vote_idx + 2'd1;
            w_ones_nxt     = w_ones_sum;
         end else begin
            w_vote_idx_nxt = 2'd0;
            w_ones_nxt     = 2'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vote_idx <= 2'd0;
         r_ones     <= 2'd0;
      end else begin
         r_vote_idx <= w_vote_idx_nxt;
         r_ones     <= w_ones_nxt;
      end
   end
`else
   assign w_race_more = 1'b0;
   assign w_bit_val   = arb_out;
`endif

   // Outputs are next-state values so every port comes straight from a flop;
   // arb_enable rises entering LOAD and falls entering CAPTURE.
   always_comb begin
      w_state_nxt  = r_state;
      w_chal_nxt   = r_chal;
      w_bit_nxt    = r_bit;
      w_data_nxt   = r_data;
      w_busy_nxt   = r_busy;
      w_launch_nxt = 1'b0;
      w_enable_nxt = r_enable;
      w_valid_nxt  = r_valid;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_chal_nxt   = challenge_seed;
               w_bit_nxt    = '0;
               w_busy_nxt   = 1'b1;
               w_enable_nxt = 1'b1;
               w_state_nxt  = LOAD;
            end
         end
         LOAD: begin
            w_launch_nxt = 1'b1;
            w_state_nxt  = LAUNCH;
         end
         LAUNCH: begin
            w_state_nxt = SETTLE;
         end
         SETTLE: begin
            if (w_tmr_done) begin
               w_enable_nxt = 1'b0;
               w_state_nxt  = CAPTURE;
            end
         end
         CAPTURE: begin
            w_state_nxt = SAMPLE;
         end
         SAMPLE: begin
            if (w_race_more) begin
               w_enable_nxt = 1'b1;
               w_state_nxt  = LOAD;
            end else begin
               w_data_nxt[r_bit] = w_bit_val;
               if (r_bit == LAST_BIT) begin
                  w_valid_nxt = 1'b1;
                  w_state_nxt = DONE;
               end else begin
                  w_bit_nxt    = r_bit + BW'(1);
                  w_chal_nxt   = r_chal + CHAL_W'(1);
                  w_enable_nxt = 1'b1;
                  w_state_nxt  = LOAD;
               end
            end
         end
         DONE: begin
            if (resp_ready) begin
               w_valid_nxt = 1'b0;
               w_busy_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_chal   <= '0;
         r_bit    <= '0;
         r_data   <= '0;
         r_busy   <= 1'b0;
         r_launch <= 1'b0;
         r_enable <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_chal   <= w_chal_nxt;
         r_bit    <= w_bit_nxt;
         r_data   <= w_data_nxt;
         r_busy   <= w_busy_nxt;
         r_launch <= w_launch_nxt;
         r_enable <= w_enable_nxt;
         r_valid  <= w_valid_nxt;
      end
   end

   assign busy        = r_busy;
   assign challenge   = r_chal;
   assign race_launch = r_launch;
   assign arb_enable  = r_enable;
   assign resp_data   = r_data;
   assign resp_valid  = r_valid;

endmodule

// File: tb/tb_puf_race_sequencer.sv
// Scoreboard bench for puf_race_sequencer: expected words and latencies are
// queued at start and compared when resp_valid appears (PUF_VOTE_EN aware).
module tb_puf_race_sequencer;

   localparam int CHAL_W    = 8;
   localparam int RESP_BITS = 16;
   localparam int SETTLE    = 8;
`ifdef PUF_VOTE_EN
   localparam int VOTES = 3;
`else
   localparam int VOTES = 1;
`endif
   localparam int PER_BIT  = VOTES * (SETTLE + 4);
   localparam int WORD_LAT = RESP_BITS * PER_BIT;

   typedef struct {
      logic [RESP_BITS-1:0] word;
      int                   latency;
   } exp_t;

   logic                 clk;
   logic                 rst_n;
   logic                 start;
   logic [CHAL_W-1:0]    challenge_seed;
   logic                 busy;
   logic [CHAL_W-1:0]    challenge;
   logic                 race_launch;
   logic                 arb_enable;
   logic                 arb_out;
   logic [RESP_BITS-1:0] resp_data;
   logic                 resp_valid;
   logic                 resp_ready;

   int checks = 0;
   int errors = 0;
   int edgeCount = 0;
   int launchCount = 0;
   int baseLaunch = 0;
   int startEdge = 0;
   int arbMode = 0;
   logic [CHAL_W-1:0]    chalSeed = '0;
   logic [RESP_BITS-1:0] lastExp = '0;
   exp_t sbQueue[$];

   puf_race_sequencer #(
      .CHAL_W        (CHAL_W),
      .RESP_BITS     (RESP_BITS),
      .SETTLE_CYCLES (SETTLE)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .challenge_seed (challenge_seed),
      .busy           (busy),
      .challenge      (challenge),
      .race_launch    (race_launch),
      .arb_enable     (arb_enable),
      .arb_out        (arb_out),
      .resp_data      (resp_data),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edgeCount++;

   // Arbiter model: constant 1, challenge LSB, or a 1,0,1 pattern per race triple.
   assign arb_out = (arbMode == 0) ? 1'b1 :
                    (arbMode == 1) ? challenge[0] :
                    (((launchCount - baseLaunch + 2) % 3) != 1);

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [RESP_BITS-1:0] expWord(input logic [CHAL_W-1:0] seed, input int mode);
      logic [RESP_BITS-1:0] w;
      logic [CHAL_W-1:0]    c;
      w = '0;
      for (int i = 0; i < RESP_BITS; i++) begin
         c = seed + CHAL_W'(i);
         w[i] = (mode == 1) ? c[0] : 1'b1;
      end
      return w;
   endfunction

   // Watches every race: challenge value, launch-to-fall spacing and enable width.
   int enHigh = 0;
   int afterLaunch = -1;
   logic prevEn = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         enHigh      = 0;
         afterLaunch = -1;
         prevEn      = 1'b0;
      end else begin
         if (arb_enable) begin
            enHigh++;
         end else if (prevEn) begin
            checkOutput("enable_width", 32'(enHigh), 32'(SETTLE + 2));
            checkOutput("launch_to_fall", 32'(afterLaunch), 32'(SETTLE));
            enHigh = 0;
         end
         if (race_launch) begin
            launchCount++;
            checkOutput("challenge", 32'(challenge),
                        32'(CHAL_W'(chalSeed + CHAL_W'((launchCount - baseLaunch - 1) / VOTES))));
            afterLaunch = 0;
         end else if (afterLaunch >= 0 && arb_enable) begin
            afterLaunch++;
         end
         prevEn = arb_enable;
      end
   end

   task automatic applyStimulus(input logic [CHAL_W-1:0] seed, input int mode);
      exp_t e;
      @(negedge clk);
      challenge_seed = seed;
      arbMode        = mode;
      chalSeed       = seed;
      baseLaunch     = launchCount;
      start          = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      startEdge = edgeCount;
      e.word    = expWord(seed, mode);
      e.latency = WORD_LAT;
      sbQueue.push_back(e);
   endtask

   task automatic waitResponse();
      exp_t e;
      int n = 0;
      while (!resp_valid && n < WORD_LAT + 200) begin
         @(negedge clk);
         n++;
      end
      if (sbQueue.size() == 0) begin
         checkOutput("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = sbQueue.pop_front();
         if (!resp_valid) begin
            checkOutput("resp_timeout", 32'd0, 32'd1);
         end else begin
            checkOutput("latency", 32'(edgeCount - startEdge), 32'(e.latency));
            checkOutput("resp_data", 32'(resp_data), 32'(e.word));
            lastExp = e.word;
         end
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_launch"}, 32'(race_launch), 32'd0);
      checkOutput({tag, "_enable"}, 32'(arb_enable), 32'd0);
      checkOutput({tag, "_valid"}, 32'(resp_valid), 32'd0);
      checkOutput({tag, "_challenge"}, 32'(challenge), 32'd0);
      checkOutput({tag, "_data"}, 32'(resp_data), 32'd0);
   endtask

   initial begin
      int bad;
      int launchesBefore;
      int n;
      exp_t dropped;
      rst_n          = 1'b0;
      start          = 1'b0;
      challenge_seed = '0;
      resp_ready     = 1'b0;

      // Reset and idle quiet period.
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      checkAllZero("reset");
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy || race_launch || arb_enable || resp_valid || challenge != '0 || resp_data != '0)
            bad++;
      end
      checkOutput("idle_quiet", 32'(bad), 32'd0);

      // All-ones arbiter with a wrapping challenge sequence, consumer ready.
      resp_ready = 1'b1;
      applyStimulus(8'hFE, 0);
      waitResponse();
      checkOutput("launch_count", 32'(launchCount - baseLaunch), 32'(RESP_BITS * VOTES));
      @(negedge clk);
      checkOutput("ready_valid_drop", 32'(resp_valid), 32'd0);
      checkOutput("ready_busy_drop", 32'(busy), 32'd0);

      // Arbiter follows challenge LSB.
      applyStimulus(8'h00, 1);
      waitResponse();
      @(negedge clk);

      // Backpressure with an ignored start while waiting in DONE.
      resp_ready = 1'b0;
      applyStimulus(8'h5B, 1);
      waitResponse();
      launchesBefore = launchCount;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (i == 10) start = 1'b1;
         if (i == 11) start = 1'b0;
         @(negedge clk);
         if (!resp_valid || !busy || resp_data !== lastExp) bad++;
      end
      start = 1'b0;
      checkOutput("bp_hold", 32'(bad), 32'd0);
      resp_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_valid_drop", 32'(resp_valid), 32'd0);
      checkOutput("bp_busy_drop", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      checkOutput("bp_start_ignored_busy", 32'(busy), 32'd0);
      checkOutput("bp_start_ignored_launch", 32'(launchCount - launchesBefore), 32'd0);

      // Reset during the fifth settle window, then a fresh full word.
      applyStimulus(8'h10, 0);
      n = 0;
      while ((launchCount - baseLaunch) < 4 * VOTES + 1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("reach_fifth_race", 32'(launchCount - baseLaunch), 32'(4 * VOTES + 1));
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkAllZero("midreset");
      if (sbQueue.size() > 0) dropped = sbQueue.pop_front();
      rst_n = 1'b1;
      applyStimulus(8'h37, 1);
      waitResponse();
      @(negedge clk);

`ifdef PUF_VOTE_EN
      // 1,0,1 per challenge must vote to 1 for every bit.
      applyStimulus(8'h00, 2);
      waitResponse();
      @(negedge clk);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
